// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch stage
package if_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } if_state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// rtl/if_pc_reg.sv - program counter register with redirect / sequential next-PC select
module if_pc_reg
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        sel_redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    // 32-bit add wraps naturally, so 0xFFFF_FFFC steps to 0.
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= sel_redirect ? align_word(redirect_pc) : pc_plus4;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - fetch FSM, hold register and imem handshake feeding IF/ID
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] Instruction,
    output logic        FetchValid
);

    if_state_t   state, state_next;
    logic [31:0] hold_q;
    logic [31:0] drop_addr_q;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_load;
    logic        pc_sel_redirect;
    logic        hold_load;
    logic        drop_capture;

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (pc_load),
        .sel_redirect (pc_sel_redirect),
        .redirect_pc  (RedirectPC),
        .pc           (pc),
        .pc_plus4     (pc_plus4)
    );

    always_comb begin
        state_next      = state;
        pc_load         = 1'b0;
        pc_sel_redirect = 1'b0;
        hold_load       = 1'b0;
        drop_capture    = 1'b0;
        if (Redirect) begin
            pc_load         = 1'b1;
            pc_sel_redirect = 1'b1;
            case (state)
                FETCH: begin
                    // An unanswered request still owes a reply that must be swallowed.
                    if (!imem_ack) begin
                        state_next   = DROP;
                        drop_capture = 1'b1;
                    end
                end
                HOLD:    state_next = FETCH;
                DROP:    state_next = imem_ack ? FETCH : DROP;
                default: state_next = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        hold_load  = 1'b1;
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (PCWrite) begin
                        pc_load    = 1'b1;
                        state_next = FETCH;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state_next = FETCH;
                    end
                end
                default: state_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            hold_q      <= NOP;
            drop_addr_q <= 32'h0;
        end else begin
            state <= state_next;
            if (hold_load) begin
                hold_q <= imem_rdata;
            end
            // The memory sees the discarded request's address until it answers.
            if (drop_capture) begin
                drop_addr_q <= pc;
            end
        end
    end

    assign imem_req    = ((state == FETCH) || (state == DROP)) && !rst;
    assign imem_addr   = (state == DROP) ? drop_addr_q : pc;
    assign FetchValid  = (state == HOLD);
    assign Instruction = FetchValid ? hold_q : NOP;
    assign PCPlus4     = FetchValid ? pc_plus4 : 32'h0;
    assign PC          = pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, PCWrite, Redirect, imem_ack;
    logic [31:0] RedirectPC, imem_rdata;
    logic        imem_req, FetchValid;
    logic [31:0] imem_addr, PC, PCPlus4, Instruction;

    logic        rst2, pcw2, red2, ack2;
    logic [31:0] rpc2, rdata2;
    logic        req2, fv2;
    logic [31:0] addr2, pc2, pp42, ins2;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        outst;
    logic        taint;
    logic [31:0] out_addr;
    int          lat;

    always #5 clk = ~clk;

    if_fetch_unit u_dut (
        .clk (clk), .rst (rst), .PCWrite (PCWrite), .Redirect (Redirect),
        .RedirectPC (RedirectPC), .imem_req (imem_req), .imem_addr (imem_addr),
        .imem_ack (imem_ack), .imem_rdata (imem_rdata), .PC (PC), .PCPlus4 (PCPlus4),
        .Instruction (Instruction), .FetchValid (FetchValid)
    );

    if_fetch_unit #(.RESET_PC (32'hFFFF_FFFC)) u_dut_hi (
        .clk (clk), .rst (rst2), .PCWrite (pcw2), .Redirect (red2),
        .RedirectPC (rpc2), .imem_req (req2), .imem_addr (addr2),
        .imem_ack (ack2), .imem_rdata (rdata2), .PC (pc2), .PCPlus4 (pp42),
        .Instruction (ins2), .FetchValid (fv2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_main();
        @(negedge clk);
        rst = 1'b1; imem_ack = 1'b0; Redirect = 1'b0; PCWrite = 1'b0;
        RedirectPC = 32'h0; imem_rdata = 32'h0;
        @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_fv", {31'b0, FetchValid}, 32'h0);
        chk("rst_ins", Instruction, 32'h0);
        chk("rst_pp4", PCPlus4, 32'h0);
        rst = 1'b0;
        outst = 1'b0; taint = 1'b0; lat = 0;
        exp_pc = 32'h0; exp_valid = 1'b0;
    endtask

    // One clock of the main DUT against the reference model.
    task automatic cycle_main(input int lat_max, input int pw_pct, input int rd_pct);
        logic        ack_now, red, pw, next_valid;
        logic [31:0] tgt;
        @(negedge clk);
        chk("fv", {31'b0, FetchValid}, {31'b0, exp_valid});
        if (exp_valid) begin
            chk("ins", Instruction, mem_word(exp_pc));
            chk("pp4", PCPlus4, exp_pc + 32'd4);
            chk("pc", PC, exp_pc);
            chk("req_in_hold", {31'b0, imem_req}, 32'h0);
        end else begin
            chk("ins_nop", Instruction, 32'h0);
            chk("pp4_zero", PCPlus4, 32'h0);
        end
        if (imem_req) begin
            if (!outst) begin
                chk("fresh_addr", imem_addr, exp_pc);
                outst = 1'b1; out_addr = imem_addr; taint = 1'b0;
                lat = $urandom_range(lat_max, 0);
            end else begin
                chk("stable_addr", imem_addr, out_addr);
            end
        end
        ack_now = outst && (lat == 0);
        if (outst && lat != 0) lat--;
        red = ($urandom_range(99, 0) < rd_pct);
        pw  = ($urandom_range(99, 0) < pw_pct);
        tgt = $urandom;
        imem_ack   = ack_now;
        imem_rdata = ack_now ? mem_word(out_addr) : $urandom;
        PCWrite    = pw;
        Redirect   = red;
        RedirectPC = tgt;
        // A reply is shown only if no redirect happened while it was in flight.
        if (red) taint = 1'b1;
        next_valid = ack_now && !taint;
        if (ack_now) outst = 1'b0;
        if (red) begin
            exp_pc = tgt & ~32'h3;
            exp_valid = 1'b0;
        end else if (exp_valid && pw) begin
            exp_pc = exp_pc + 32'd4;
            exp_valid = 1'b0;
        end
        if (next_valid) exp_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; PCWrite = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        rst2 = 1'b1; pcw2 = 1'b0; red2 = 1'b0; rpc2 = 32'h0; ack2 = 1'b0; rdata2 = 32'h0;
        exp_pc = 32'h0; exp_valid = 1'b0; outst = 1'b0; taint = 1'b0; out_addr = 32'h0; lat = 0;

        reset_main();
        for (int i = 0; i < 8; i++) cycle_main(0, 100, 0);
        reset_main();
        for (int i = 0; i < 400; i++) cycle_main(3, 60, 8);
        reset_main();
        for (int i = 0; i < 400; i++) cycle_main(4, 30, 25);
        reset_main();
        for (int i = 0; i < 300; i++) cycle_main(1, 80, 4);

        // High reset PC: wrap of PC+4 and reset taken while holding a word.
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        chk("hi_rst_req", {31'b0, req2}, 32'h0);
        chk("hi_rst_pc", pc2, 32'hFFFF_FFFC);
        rst2 = 1'b0;
        @(negedge clk);
        chk("hi_req", {31'b0, req2}, 32'h1);
        chk("hi_addr", addr2, 32'hFFFF_FFFC);
        ack2 = 1'b1; rdata2 = 32'h1234_5678;
        @(negedge clk);
        ack2 = 1'b0;
        chk("hi_fv", {31'b0, fv2}, 32'h1);
        chk("hi_ins", ins2, 32'h1234_5678);
        chk("hi_pp4_wrap", pp42, 32'h0);
        chk("hi_req_hold", {31'b0, req2}, 32'h0);
        pcw2 = 1'b1;
        @(negedge clk);
        pcw2 = 1'b0;
        chk("hi_fv_after", {31'b0, fv2}, 32'h0);
        chk("hi_wrap_addr", addr2, 32'h0);
        chk("hi_req2", {31'b0, req2}, 32'h1);
        ack2 = 1'b1; rdata2 = 32'h8C01_0004;
        @(negedge clk);
        ack2 = 1'b0;
        chk("hi_fv2", {31'b0, fv2}, 32'h1);
        chk("hi_ins2", ins2, 32'h8C01_0004);
        chk("hi_pp4_2", pp42, 32'h4);
        rst2 = 1'b1;
        @(negedge clk);
        chk("hi_rst_fv", {31'b0, fv2}, 32'h0);
        chk("hi_rst_ins", ins2, 32'h0);
        chk("hi_rst_pp4", pp42, 32'h0);
        chk("hi_rst_req2", {31'b0, req2}, 32'h0);
        rst2 = 1'b0;
        @(negedge clk);
        chk("hi_refetch", addr2, 32'hFFFF_FFFC);
        chk("hi_refetch_req", {31'b0, req2}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
